// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl
// Sequencing controller for a WIDTH-bit parallel-in/serial-out shift register.
// It arbitrates two word requesters round-robin, loads the winner's word into
// the PISO through SH_LDN/PD, and times the serial frame. An optional idle gap
// can follow each frame. Every output comes straight from a flop.

module piso_tx_ctrl #(
    parameter int WIDTH      = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] D0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             SH_LDN,
    output logic [WIDTH-1:0] PD,
    output logic             FRAME,
    output logic             DONE,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_e;

    // One counter times both the shift phase and the gap phase.
    localparam int CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             rr_q,     rr_d;      // 1 = requester 1 was granted last
    logic             gnt0_q,   gnt0_d;
    logic             gnt1_q,   gnt1_d;
    logic             sh_ldn_q, sh_ldn_d;
    logic [WIDTH-1:0] pd_q,     pd_d;
    logic             frame_q,  frame_d;
    logic             done_q,   done_d;
    logic             busy_q,   busy_d;

    logic any_req;
    logic pick1;
    logic decide;

    // Round-robin choice: a lone request wins; on a tie the requester not granted last wins.
    assign any_req = REQ0 | REQ1;
    assign pick1   = REQ1 & (~REQ0 | ~rr_q);

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_d     = rr_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        sh_ldn_d = 1'b1;
        pd_d     = pd_q;
        frame_d  = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        decide   = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                decide = 1'b1;
            end

            LOAD: begin
                // PISO captures PD at this edge; the first bit is on Q next cycle.
                state_d = SHIFT;
                cnt_d   = '0;
                frame_d = 1'b1;
                busy_d  = 1'b1;
            end

            SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == BIT_LAST) begin
                    done_d = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        decide = 1'b1;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    frame_d = 1'b1;
                end
            end

            GAP: begin
                busy_d = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    decide = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Frame-end / idle decision: start the next word or fall back to IDLE.
        if (decide) begin
            if (any_req) begin
                state_d  = LOAD;
                sh_ldn_d = 1'b0;
                busy_d   = 1'b1;
                rr_d     = pick1;
                gnt0_d   = ~pick1;
                gnt1_d   = pick1;
                pd_d     = pick1 ? D1 : D0;
            end else begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_q     <= 1'b1;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            sh_ldn_q <= 1'b1;
            pd_q     <= '0;
            frame_q  <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            sh_ldn_q <= sh_ldn_d;
            pd_q     <= pd_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign SH_LDN = sh_ldn_q;
    assign PD     = pd_q;
    assign FRAME  = frame_q;
    assign DONE   = done_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl
// Directed bench for piso_tx_ctrl. Two instances share the stimulus: one with
// no gap and one with a two-cycle gap. A small PISO model on the no-gap
// instance reconstructs the serial line. Cycle n is the interval after edge n.

module tb_piso_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req0, req1;
    logic [3:0] d0, d1;

    logic       gnt0_a, gnt1_a, sh_ldn_a, frame_a, done_a, busy_a;
    logic [3:0] pd_a;
    logic       gnt0_b, gnt1_b, sh_ldn_b, frame_b, done_b, busy_b;
    logic [3:0] pd_b;

    logic [3:0] piso_q;

    int n_vec = 0;
    int n_bad = 0;

    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(0)) u_dut_g0 (
        .CLK(clk), .RSTN(rst_n),
        .REQ0(req0), .D0(d0), .REQ1(req1), .D1(d1),
        .GNT0(gnt0_a), .GNT1(gnt1_a), .SH_LDN(sh_ldn_a), .PD(pd_a),
        .FRAME(frame_a), .DONE(done_a), .BUSY(busy_a)
    );

    piso_tx_ctrl #(.WIDTH(4), .GAP_CYCLES(2)) u_dut_g2 (
        .CLK(clk), .RSTN(rst_n),
        .REQ0(req0), .D0(d0), .REQ1(req1), .D1(d1),
        .GNT0(gnt0_b), .GNT1(gnt1_b), .SH_LDN(sh_ldn_b), .PD(pd_b),
        .FRAME(frame_b), .DONE(done_b), .BUSY(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PISO model: load on SH_LDN=0, otherwise shift MSB-first.
    always @(posedge clk) begin
        if (!sh_ldn_a) piso_q <= pd_a;
        else           piso_q <= {piso_q[2:0], 1'b0};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Output bundle {GNT0,GNT1,SH_LDN,FRAME,DONE,BUSY,PD}.
    function automatic logic [31:0] outs_a();
        return {22'd0, gnt0_a, gnt1_a, sh_ldn_a, frame_a, done_a, busy_a, pd_a};
    endfunction

    function automatic logic [31:0] outs_b();
        return {22'd0, gnt0_b, gnt1_b, sh_ldn_b, frame_b, done_b, busy_b, pd_b};
    endfunction

    function automatic logic [31:0] ex(input logic g0, input logic g1, input logic sl,
                                       input logic fr, input logic dn, input logic bz,
                                       input logic [3:0] pd);
        return {22'd0, g0, g1, sl, fr, dn, bz, pd};
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        d0    = 4'd0;
        d1    = 4'd0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] w;
        logic [3:0] wpd;
        int         ph;
        int         fr;

        // ---- 1. reset mid-idle, then 20 quiet cycles ----
        apply_reset();
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_g0", outs_a(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        check("rst_async_g2", outs_b(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_g0", outs_a(), ex(0, 0, 1, 0, 0, 0, 4'd0));
            check("idle_g2", outs_b(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        end

        // ---- 2. single request, D0=1101 ----
        apply_reset();
        w    = 4'b1101;
        req0 = 1'b1;
        d0   = w;
        tick();
        check("single_c0", outs_a(), ex(1, 0, 0, 0, 0, 1, w));
        req0 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("single_frame", outs_a(), ex(0, 0, 1, 1, 0, 1, w));
            check("single_q", {31'd0, piso_q[3]}, {31'd0, w[4 - c]});
        end
        tick();
        check("single_done", outs_a(), ex(0, 0, 1, 0, 1, 0, w));
        tick();
        check("single_idle", outs_a(), ex(0, 0, 1, 0, 0, 0, w));

        // ---- 3 & 4. tie, both requests held: period 5 (no gap) and 7 (gap 2) ----
        apply_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        d0   = 4'b1101;
        d1   = 4'b0010;
        for (int c = 0; c < 21; c++) begin
            tick();
            ph  = c % 5;
            fr  = c / 5;
            wpd = (fr % 2 == 0) ? 4'b1101 : 4'b0010;
            check("tie_g0", outs_a(),
                  ex((ph == 0) && (fr % 2 == 0), (ph == 0) && (fr % 2 == 1),
                     ph != 0, ph != 0, (ph == 0) && (c > 0), 1'b1, wpd));
            check("tie_no_overlap", {31'd0, gnt0_a & gnt1_a}, 32'd0);
            ph  = c % 7;
            fr  = c / 7;
            wpd = (fr % 2 == 0) ? 4'b1101 : 4'b0010;
            check("gap_g2", outs_b(),
                  ex((ph == 0) && (fr % 2 == 0), (ph == 0) && (fr % 2 == 1),
                     ph != 0, (ph >= 1) && (ph <= 4), ph == 5, 1'b1, wpd));
        end

        // ---- 5. reset in cycle 2 of a frame; pointer returns to favour REQ0 ----
        apply_reset();
        req0 = 1'b1;
        req1 = 1'b1;
        d0   = 4'b1101;
        d1   = 4'b0010;
        tick();
        check("mid_rst_c0_gnt", {30'd0, gnt0_a, gnt1_a}, 32'b10);
        tick();
        tick();
        check("mid_rst_pre", {30'd0, frame_a, busy_a}, 32'b11);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_now_g0", outs_a(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        check("mid_rst_now_g2", outs_b(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        tick();
        check("mid_rst_no_done", outs_a(), ex(0, 0, 1, 0, 0, 0, 4'd0));
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_rr_g0", outs_a(), ex(1, 0, 0, 0, 0, 1, 4'b1101));
        check("mid_rst_rr_g2", outs_b(), ex(1, 0, 0, 0, 0, 1, 4'b1101));

        // ---- 6. no preemption: REQ1 granted, REQ0 rises in cycle 2 ----
        apply_reset();
        req1 = 1'b1;
        d1   = 4'b0010;
        tick();
        check("nopre_c0", outs_a(), ex(0, 1, 0, 0, 0, 1, 4'b0010));
        req1 = 1'b0;
        tick();
        check("nopre_c1_gnt", {30'd0, gnt0_a, gnt1_a}, 32'd0);
        tick();
        req0 = 1'b1;
        d0   = 4'b1101;
        for (int c = 2; c <= 4; c++) begin
            check("nopre_hold", {30'd0, gnt0_a, gnt1_a}, 32'd0);
            tick();
        end
        check("nopre_c5", outs_a(), ex(1, 0, 0, 0, 1, 1, 4'b1101));
        req0 = 1'b0;
        tick();
        check("nopre_c6", outs_a(), ex(0, 0, 1, 1, 0, 1, 4'b1101));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
